// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM state encoding
// and default bus widths.
package mem_arb_pkg;

   localparam int MEM_AW_DEF = 32;
   localparam int MEM_DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2,
      RESP    = 2'd3
   } arbState_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port
// and the load/store port. Data requests have fixed priority over fetches.
// All mem_* outputs are registers, so there is always an IDLE bubble between
// two accesses.
// Optional feature: define MEM_ARB_RDATA_REG_EN to register read data at the
// completion edge and pulse *_valid one cycle later from a RESP state. This
// cuts the mem_rdata -> InstF/ReadDataM combinational path.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_AW = MEM_AW_DEF,
   parameter int MEM_DW = MEM_DW_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   // fetch port
   input  logic                  if_req,
   input  logic [MEM_AW-1:0]     if_addr,
   output logic [MEM_DW-1:0]     if_rdata,
   output logic                  if_valid,
   // load/store port
   input  logic                  dm_req,
   input  logic [MEM_DW/8-1:0]   dm_we,
   input  logic [MEM_AW-1:0]     dm_addr,
   input  logic [MEM_DW-1:0]     dm_wdata,
   output logic [MEM_DW-1:0]     dm_rdata,
   output logic                  dm_valid,
   // memory side
   output logic                  mem_en,
   output logic [MEM_DW/8-1:0]   mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [MEM_DW-1:0]     mem_wdata,
   input  logic [MEM_DW-1:0]     mem_rdata,
   input  logic                  mem_ready,
   // hazard unit
   output logic                  stall_if,
   output logic                  stall_mem
);

`ifdef MEM_ARB_RDATA_REG_EN
   localparam arbState_t DONE_STATE = RESP;
`else
   localparam arbState_t DONE_STATE = IDLE;
`endif

   arbState_t state, stateNext;
   logic      ifDone, dmDone;

   // A completion only counts as delivered if the requester still wants it;
   // a flushed requester lets the memory finish but gets no pulse.
   assign ifDone = (state == IF_BUSY) & mem_ready & if_req;
   assign dmDone = (state == DM_BUSY) & mem_ready & dm_req;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   // Next-state: data over fetch from IDLE, leave BUSY on mem_ready
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (dm_req)      stateNext = DM_BUSY;
            else if (if_req) stateNext = IF_BUSY;
         end
         IF_BUSY, DM_BUSY: begin
            if (mem_ready) stateNext = DONE_STATE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Latch the winning request into the memory outputs on acceptance;
   // drop mem_en at the completion edge. Address/data simply hold afterwards.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_en    <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dm_req) begin
                  mem_en    <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
               end else if (if_req) begin
                  mem_en    <= 1'b1;
                  mem_we    <= '0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end
            end
            IF_BUSY, DM_BUSY: begin
               if (mem_ready) mem_en <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_ARB_RDATA_REG_EN
   logic [MEM_DW-1:0] ifRdataQ, dmRdataQ;
   logic              ifValidQ, dmValidQ;

   // Capture read data at the completion edge; valid pulses during RESP
   always_ff @(posedge clk) begin
      if (!rst) begin
         ifRdataQ <= '0;
         dmRdataQ <= '0;
         ifValidQ <= 1'b0;
         dmValidQ <= 1'b0;
      end else begin
         ifValidQ <= ifDone;
         dmValidQ <= dmDone;
         if ((state == IF_BUSY) && mem_ready) ifRdataQ <= mem_rdata;
         if ((state == DM_BUSY) && mem_ready) dmRdataQ <= mem_rdata;
      end
   end

   assign if_rdata = ifRdataQ;
   assign dm_rdata = dmRdataQ;
   assign if_valid = ifValidQ;
   assign dm_valid = dmValidQ;
`else
   // Read data passes straight through; it is only meaningful with *_valid
   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;
   assign if_valid = ifDone;
   assign dm_valid = dmDone;
`endif

   assign stall_if  = if_req & ~if_valid;
   assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Expected latencies
// adapt to MEM_ARB_RDATA_REG_EN (one extra response cycle when defined).
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RDATA_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic [3:0]  dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;

   int nCmp  = 0;
   int nFail = 0;

   mem_port_arbiter #(.MEM_AW(32), .MEM_DW(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are driven from here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
      dm_wdata = 0; mem_rdata = 0; mem_ready = 0;
      tick(); tick();
      #1;
      nCmp++; if (mem_en !== 1'b0) begin nFail++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
      nCmp++; if ({mem_we, mem_addr, mem_wdata} !== 68'h0) begin nFail++;
         $display("FAIL reset_mem_bus got we=%h addr=%h wd=%h want 0", mem_we, mem_addr, mem_wdata); end
      nCmp++; if ({if_valid, dm_valid, stall_if, stall_mem} !== 4'b0) begin nFail++;
         $display("FAIL reset_valid_stall got %b want 0000", {if_valid, dm_valid, stall_if, stall_mem}); end
      if (LAT == 1) begin
         nCmp++; if ({if_rdata, dm_rdata} !== 64'h0) begin nFail++;
            $display("FAIL reset_rdata got %h %h want 0", if_rdata, dm_rdata); end
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_zero_wait_fetch();
      if_req = 1; if_addr = 32'h0000_0040; mem_ready = 1; mem_rdata = 32'h2408_0005;
      #1;
      nCmp++; if ({mem_en, stall_if, if_valid} !== 3'b010) begin nFail++;
         $display("FAIL zw_idle got en/stall/vld=%b want 010", {mem_en, stall_if, if_valid}); end
      tick(); #1;
      nCmp++; if ({mem_en, mem_addr, mem_we} !== {1'b1, 32'h40, 4'h0}) begin nFail++;
         $display("FAIL zw_issue got en=%b addr=%h we=%h want 1 40 0", mem_en, mem_addr, mem_we); end
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) begin tick(); #1; end
         nCmp++; if ({if_valid, stall_if} !== ((k == LAT) ? 2'b10 : 2'b01)) begin nFail++;
            $display("FAIL zw_valid k=%0d got vld/stall=%b%b", k, if_valid, stall_if); end
      end
      nCmp++; if (if_rdata !== 32'h2408_0005) begin nFail++;
         $display("FAIL zw_rdata got %h want 24080005", if_rdata); end
      if_req = 0;
      tick(); #1;
      nCmp++; if ({mem_en, if_valid} !== 2'b00) begin nFail++;
         $display("FAIL zw_after got en/vld=%b want 00", {mem_en, if_valid}); end
   endtask

   task automatic test_priority();
      if_req = 1; if_addr = 32'h80;
      dm_req = 1; dm_we = 4'hF; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
      mem_ready = 1; mem_rdata = 32'h0;
      tick(); #1;
      nCmp++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin nFail++;
         $display("FAIL prio_store got en=%b we=%h addr=%h wd=%h", mem_en, mem_we, mem_addr, mem_wdata); end
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) begin tick(); #1; end
         nCmp++; if ({dm_valid, if_valid, stall_if} !== ((k == LAT) ? 3'b101 : 3'b001)) begin nFail++;
            $display("FAIL prio_dvalid k=%0d got dv/iv/sif=%b%b%b", k, dm_valid, if_valid, stall_if); end
      end
      dm_req = 0; dm_we = 0;
      mem_rdata = 32'h0000_0013;
      tick(); #1;
      nCmp++; if ({mem_en, if_valid} !== 2'b00) begin nFail++;
         $display("FAIL prio_bubble got en/iv=%b want 00", {mem_en, if_valid}); end
      tick(); #1;
      nCmp++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'h0, 32'h80}) begin nFail++;
         $display("FAIL prio_fetch got en=%b we=%h addr=%h want 1 0 80", mem_en, mem_we, mem_addr); end
      for (int k = 0; k < LAT; k++) begin tick(); #1; end
      nCmp++; if ({if_valid, if_rdata} !== {1'b1, 32'h0000_0013}) begin nFail++;
         $display("FAIL prio_fetch_done got vld=%b data=%h want 1 00000013", if_valid, if_rdata); end
      if_req = 0;
      tick(); #1;
   endtask

   task automatic test_wait_states();
      int pulses = 0;
      dm_req = 1; dm_we = 0; dm_addr = 32'h200; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
      tick(); #1;
      dm_addr = 32'h9999_0000;   // must be ignored while busy
      for (int w = 0; w < 4; w++) begin
         if (w == 3) begin mem_ready = 1; mem_rdata = 32'h1234_5678; end
         #1;
         nCmp++; if ({mem_en, mem_addr, stall_mem} !== {1'b1, 32'h200, (LAT == 0 && w == 3) ? 1'b0 : 1'b1}) begin nFail++;
            $display("FAIL wait_hold w=%0d got en=%b addr=%h stall=%b", w, mem_en, mem_addr, stall_mem); end
         if (dm_valid === 1'b1) pulses++;
         if (w < 3) tick();
      end
      if (LAT == 0) begin
         nCmp++; if (dm_rdata !== 32'h1234_5678) begin nFail++;
            $display("FAIL wait_rdata got %h want 12345678", dm_rdata); end
      end
      tick();
      mem_ready = 0; mem_rdata = 32'hAAAA_AAAA;
      #1;
      if (LAT == 1) begin
         nCmp++; if ({dm_valid, dm_rdata} !== {1'b1, 32'h1234_5678}) begin nFail++;
            $display("FAIL wait_rdata_reg got vld=%b data=%h want 1 12345678", dm_valid, dm_rdata); end
      end
      if (dm_valid === 1'b1) pulses++;
      dm_req = 0;
      tick(); #1;
      if (dm_valid === 1'b1) pulses++;
      nCmp++; if (pulses !== 1) begin nFail++;
         $display("FAIL wait_pulses got %0d want 1", pulses); end
      tick();
   endtask

   task automatic test_flush();
      if_req = 1; if_addr = 32'h44; mem_ready = 0;
      tick();
      if_req = 0; mem_ready = 1; mem_rdata = 32'h5555_5555;
      #1;
      nCmp++; if ({mem_en, if_valid, stall_if} !== 3'b100) begin nFail++;
         $display("FAIL flush_complete got en/vld/stall=%b want 100", {mem_en, if_valid, stall_if}); end
      tick(); mem_ready = 0; #1;
      nCmp++; if ({mem_en, if_valid} !== 2'b00) begin nFail++;
         $display("FAIL flush_after1 got en/vld=%b want 00", {mem_en, if_valid}); end
      tick(); #1;
      nCmp++; if ({mem_en, if_valid} !== 2'b00) begin nFail++;
         $display("FAIL flush_after2 got en/vld=%b want 00", {mem_en, if_valid}); end
   endtask

   task automatic test_reset_mid();
      dm_req = 1; dm_we = 4'hF; dm_addr = 32'h300; dm_wdata = 32'h0000_CAFE; mem_ready = 0;
      tick(); #1;
      nCmp++; if ({mem_en, mem_addr} !== {1'b1, 32'h300}) begin nFail++;
         $display("FAIL rmid_busy got en=%b addr=%h want 1 300", mem_en, mem_addr); end
      rst = 0;
      tick(); #1;
      nCmp++; if ({mem_en, mem_we, mem_addr, mem_wdata, if_valid, dm_valid} !== 71'h0) begin nFail++;
         $display("FAIL rmid_cleared got en=%b we=%h addr=%h wd=%h iv=%b dv=%b",
                  mem_en, mem_we, mem_addr, mem_wdata, if_valid, dm_valid); end
      rst = 1; dm_req = 0; dm_we = 0;
      if_req = 1; if_addr = 32'h48; mem_ready = 1; mem_rdata = 32'h0000_0033;
      tick(); #1;
      nCmp++; if ({mem_en, mem_addr, mem_we} !== {1'b1, 32'h48, 4'h0}) begin nFail++;
         $display("FAIL rmid_fetch got en=%b addr=%h we=%h want 1 48 0", mem_en, mem_addr, mem_we); end
      for (int k = 0; k < LAT; k++) begin tick(); #1; end
      nCmp++; if ({if_valid, if_rdata} !== {1'b1, 32'h0000_0033}) begin nFail++;
         $display("FAIL rmid_fetch_done got vld=%b data=%h want 1 00000033", if_valid, if_rdata); end
      if_req = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int first  = 1 + LAT;
      int second = 1 + LAT + 2 + LAT;
      dm_req = 1; dm_we = 0; dm_addr = 32'h400; mem_ready = 1; mem_rdata = 32'h0A0A_0001;
      for (int c = 0; c <= second; c++) begin
         if (c > 0) tick();
         #1;
         nCmp++; if (dm_valid !== ((c == first) || (c == second))) begin nFail++;
            $display("FAIL b2b_valid c=%0d got %b", c, dm_valid); end
         if (dm_valid === 1'b1) begin
            pulses++;
            if (c == first) begin
               if (dm_rdata !== 32'h0A0A_0001) begin nFail++;
                  $display("FAIL b2b_rdata0 got %h want 0a0a0001", dm_rdata); end
               nCmp++;
               dm_addr = 32'h404; mem_rdata = 32'h0B0B_0002;
            end else begin
               nCmp++; if ({dm_rdata, mem_addr} !== {32'h0B0B_0002, 32'h404}) begin nFail++;
                  $display("FAIL b2b_second got data=%h addr=%h want 0b0b0002 404", dm_rdata, mem_addr); end
               dm_req = 0;
            end
         end
      end
      tick(); #1;
      if (dm_valid === 1'b1) pulses++;
      nCmp++; if (pulses !== 2) begin nFail++;
         $display("FAIL b2b_pulses got %0d want 2", pulses); end
   endtask

   initial begin
      test_reset();
      test_zero_wait_fetch();
      test_priority();
      test_wait_states();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

   // Absolute watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog timeout compared=%0d", nCmp);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the IF stage fetch port and the MEM stage load/store port of the five-stage pipeline. The block serialises requests with a small FSM, drives the memory handshake, and returns read data and completion pulses to each stage. It also produces the stall requests that the hazard unit merges into StallF/StallD/StallE, so that a stage waits while its access is outstanding.

## Interface
- `MEM_AW`, default 32: memory byte-address width.
- `MEM_DW`, default 32: data width; `MEM_DW/8` byte enables.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_req` in 1: fetch request, held until `if_valid`.
- `if_addr` in MEM_AW: fetch address (PCF).
- `if_rdata` out MEM_DW: fetched instruction (InstF).
- `if_valid` out 1: one-cycle completion pulse for a fetch.
- `dm_req` in 1: data request, held until `dm_valid`.
- `dm_we` in MEM_DW/8: byte write enables; all-zero means load.
- `dm_addr` in MEM_AW: data address (EXResultM).
- `dm_wdata` in MEM_DW: store data (WriteDataM).
- `dm_rdata` out MEM_DW: load data (ReadDataM).
- `dm_valid` out 1: one-cycle completion pulse for a data access.
- `mem_en` out 1: memory request, held until `mem_ready`.
- `mem_we` out MEM_DW/8: byte write enables to memory.
- `mem_addr` out MEM_AW: memory address.
- `mem_wdata` out MEM_DW: memory write data.
- `mem_rdata` in MEM_DW: memory read data, valid when `mem_ready` is high.
- `mem_ready` in 1: memory completes the current request this cycle.
- `stall_if` out 1: fetch outstanding.
- `stall_mem` out 1: data access outstanding.

## Operation
- FSM states:
  - IDLE: memory is free.
  - IF_BUSY: fetch in flight.
  - DM_BUSY: data access in flight.
  - RESP: present only with the macro; one-cycle response state.
- Transitions out of IDLE:
  - `dm_req` -> DM_BUSY.
  - else `if_req` -> IF_BUSY.
  - else stay in IDLE.
  - When both requests are high, data wins. The MEM instruction is older, so this is fixed priority and cannot starve the pipeline.
- On entering a BUSY state, the requester's address, write enables and write data are latched into registered `mem_*` outputs. `mem_en` = 1 throughout the BUSY state.
  - For fetches, `mem_we` is always 0.
- Completion in a BUSY state with `mem_ready` = 1:
  - `mem_en` drops on the next edge.
  - The state returns to IDLE, or goes to RESP with the macro.
- A request arriving while the other requester is being served waits. No preemption.
- Requester inputs are ignored while BUSY; only the latched copy is used.
- Abandoned requester: if the requester's `*_req` is low in the completion cycle (flush), the memory transaction still completes but the corresponding `*_valid` is suppressed.
- `stall_if` = `if_req & ~if_valid`.
- `stall_mem` = `dm_req & ~dm_valid`.
- Both stall outputs are combinational from the inputs and the valid pulses.
- Reset (`rst` low at an edge), including mid-transaction:
  - State -> IDLE.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `if_valid` and `dm_valid` = 0; `if_rdata` and `dm_rdata` = 0 in registered mode.
  - Any in-flight access is dropped. Memory must tolerate `mem_en` falling without `mem_ready`.

## Timing
- Request seen in IDLE at edge t -> `mem_en` high from t+1.
- Zero-wait memory (`mem_ready` high in the first BUSY cycle): `*_valid` at cycle t+1, and the next request is accepted at edge t+2.
- Every memory wait cycle adds one cycle.
- Minimum throughput is one access per 2 cycles. The IDLE bubble is intentional, keeping all `mem_*` outputs as registers.
- Without the macro, `*_rdata` equals `mem_rdata` combinationally in the completion cycle; it is undefined otherwise.

## Configuration
- `MEM_ARB_RDATA_REG_EN` defined:
  - Read data is registered into `if_rdata`/`dm_rdata` at the completion edge.
  - `*_valid` fires in the following RESP cycle, so latency is +1 cycle.
  - The registered data holds until the next completion.
  - This breaks the mem_rdata -> InstF/ReadDataM combinational path.
- Not defined: there is no RESP state, and data and valid are combinational as described under Timing.

## Structure
- Shared package `mem_arb_pkg`: FSM state encoding (IDLE=0, IF_BUSY=1, DM_BUSY=2, RESP=3) and the default width constants.
- No sub-modules. FSM, request latch and optional read register stay in one module of roughly 150–250 lines.

## Test plan
- Zero-wait fetch: `if_req`=1, `if_addr`=0x0000_0040, `mem_ready` tied 1, `mem_rdata`=0x2408_0005 -> `mem_en` high the cycle after the request, then `if_valid` pulses with `if_rdata`=0x2408_0005 (one cycle later with the macro); `stall_if` = 1 until then.
- Simultaneous requests:
  - Stimulus: `if_req` and `dm_req` rise together; `dm_we`=4'b1111, `dm_addr`=0x100, `dm_wdata`=0xDEAD_BEEF.
  - Response: store issued first with `mem_we`=4'hF; fetch issued only after `dm_valid`.
- Wait states:
  - Stimulus: load with `mem_ready` low for 3 cycles.
  - Response: `mem_en` and `mem_addr` stable for 4 cycles, `stall_mem` high throughout, single `dm_valid` pulse.
- Flush in flight: `if_req` dropped while IF_BUSY -> transaction completes on `mem_ready`, `if_valid` stays 0.
- Reset mid-access: `rst` low while DM_BUSY -> next cycle `mem_en`=0, all outputs 0, state IDLE; a new fetch after release completes normally.
- Back-to-back loads: `dm_req` held high for two consecutive accesses with zero-wait memory -> `dm_valid` every 2 cycles (3 with the macro), no lost or duplicated pulses.
